regfile_demux32: RTL and testbench
==================================

# regfile_demux32

32-entry, N_BITS-wide general-purpose register file with one write port and two read ports. The write side is the counterpart of the 32-to-1 read-select path. A 5-to-32 one-hot write decoder (demux) steers a single write enable to exactly one register per cycle. The block sits in the decode stage of the pipelined datapath: the writeback stage drives the write port, and decode reads the rs1/rs2 operands.

## Interface
Parameters:
- N_BITS, 32, data width of every register and of the read/write data ports
- BYPASS, 1, when 1 a same-cycle write to a register being read is forwarded to the read port; when 0 reads return only stored values

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset; clears all 32 registers immediately on assertion
- we  input  1  write enable, sampled on the rising edge of clk
- waddr  input  5  register index to write
- wdata  input  N_BITS  write data
- raddr0  input  5  read port 0 register index
- raddr1  input  5  read port 1 register index
- rdata0  output  N_BITS  read port 0 data
- rdata1  output  N_BITS  read port 1 data
- wsel  output  32  one-hot decoded write strobe (debug/observation); bit k is 1 iff a write to register k is enabled this cycle

## Operation
- Storage: 32 registers, reg[0]..reg[31], each N_BITS wide.
- Write decode:
  - wsel[k] = we & (waddr == k) & rst_n, for k = 1..31.
  - wsel[0] is tied to 0: register 0 is hardwired zero and writes to it are discarded.
- Write:
  - On the rising edge of clk with rst_n high, reg[k] <= wdata for the single k where wsel[k] = 1.
  - All other registers hold their value.
  - At most one register changes per cycle.
- Read:
  - Combinational. rdataN = reg[raddrN].
  - raddrN == 0 always returns 0, including under bypass.
- Bypass (BYPASS = 1):
  - If we = 1, waddr == raddrN, raddrN != 0 and rst_n = 1, then rdataN = wdata in the same cycle, before the edge.
  - Both ports may bypass simultaneously.
- Reset:
  - rst_n low asynchronously forces every reg[k] to 0.
  - While rst_n is low: wsel = 0, bypass is suppressed, and rdata0 = rdata1 = 0.
  - A clock edge while rst_n is low performs no write.
- Width rule: wdata is stored unmodified; no sign or zero extension inside the block.

## Timing
- Reset values: every register 0, rdata0 = 0, rdata1 = 0, wsel = 0.
- Write latency:
  - Data presented in cycle T with we = 1 is visible on a non-bypassed read from cycle T+1, after the edge.
  - With BYPASS = 1 it is visible in cycle T itself.
- Read latency: 0 cycles, purely combinational from raddrN and register state.
- Simultaneous events:
  - Write and read to the same nonzero index in one cycle: rdata shows wdata if BYPASS = 1, otherwise the old value. The stored value is the new value from T+1.
  - Two read ports on the same index return identical data.
- Reset mid-operation:
  - rst_n falling at any time clears state without waiting for clk.
  - A write whose edge coincides with rst_n low is lost.
  - First write takes effect on the first rising edge after rst_n returns high.
- No internal state other than the 32 registers; no stall or handshake.

## Test plan
- Reset: hold rst_n = 0 with we = 1, waddr = 5, wdata = 0xDEADBEEF and clock 3 edges. Then release and read raddr0 = 5 with we = 0 -> rdata0 = 0x00000000, wsel = 0 throughout reset.
- Write/read all: for k = 1..31, write wdata = k*0x01010101, then read every k on both ports -> rdataN = k*0x01010101. During each write, wsel = 1<<k exactly.
- Register 0: write we = 1, waddr = 0, wdata = 0xFFFFFFFF, then read raddr0 = 0 -> rdata0 = 0 in the write cycle and after. wsel = 0.
- Bypass, with reg[7] = 0x11111111:
  - BYPASS = 1: write waddr = 7, wdata = 0x22222222 with raddr0 = raddr1 = 7 -> both rdata = 0x22222222 before the edge.
  - BYPASS = 0: the same stimulus returns 0x11111111 before the edge and 0x22222222 after.
- Async reset mid-stream: reg[3] = 0xA5A5A5A5. Drop rst_n between clock edges -> rdata0 (raddr0 = 3) becomes 0 with no clock edge. Release, write reg[3] = 0x5 -> reads 0x5 on the next cycle.
- we = 0 hold: apply random waddr/wdata for 10 cycles with we = 0 -> all registers unchanged and wsel = 0.

Source files
------------

// File: rtl/regfile_demux32.sv
// 32 x N_BITS register file: one write port through a one-hot decoder, two combinational read ports.
// Writes land on the rising edge; reads have zero latency with optional same-cycle forwarding; no stall path.
module regfile_demux32 #(
  parameter int N_BITS = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [N_BITS-1:0] wdata,
  input  logic [4:0]        raddr0,
  input  logic [4:0]        raddr1,
  output logic [N_BITS-1:0] rdata0,
  output logic [N_BITS-1:0] rdata1,
  output logic [31:0]       wsel
);

  // Register 0 is hardwired zero, so it has no storage.
  logic [N_BITS-1:0] regs [1:31];

  always_comb begin
    wsel = '0;
    for (int k = 1; k < 32; k++) begin
      wsel[k] = we && (waddr == 5'(k)) && rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < 32; k++) begin
        regs[k] <= '0;
      end
    end else begin
      for (int k = 1; k < 32; k++) begin
        if (wsel[k]) begin
          regs[k] <= wdata;
        end
      end
    end
  end

  // Forwarding is gated by rst_n through the outer condition, so reset forces zero on both ports.
  always_comb begin
    rdata0 = '0;
    if (rst_n && raddr0 != 5'd0) begin
      if (BYPASS && we && waddr == raddr0) begin
        rdata0 = wdata;
      end else begin
        rdata0 = regs[raddr0];
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst_n && raddr1 != 5'd0) begin
      if (BYPASS && we && waddr == raddr1) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs[raddr1];
      end
    end
  end

endmodule

// File: tb/tb_regfile_demux32.sv
// Directed bench for regfile_demux32; a forwarding and a non-forwarding instance share all inputs.
module tb_regfile_demux32;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr0;
  logic [4:0]  raddr1;
  logic [31:0] rdata0, rdata1, rdata0_nb, rdata1_nb;
  logic [31:0] wsel, wsel_nb;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [0:31];

  regfile_demux32 #(.N_BITS(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1), .wsel(wsel)
  );

  regfile_demux32 #(.N_BITS(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0_nb), .rdata1(rdata1_nb), .wsel(wsel_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr0 = 5'd5; raddr1 = 5'd5;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (wsel !== 32'h0 || wsel_nb !== 32'h0) begin
        errors++; $display("FAIL reset_wsel: got %h/%h expected 00000000", wsel, wsel_nb);
      end
      checks++;
      if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
        errors++; $display("FAIL reset_bypass_suppressed: got %h/%h expected 0", rdata0, rdata1);
      end
    end
    we = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdata0 !== 32'h0 || rdata0_nb !== 32'h0) begin
      errors++; $display("FAIL reset_write_lost: got %h/%h expected 0", rdata0, rdata0_nb);
    end
    checks++;
    if (wsel !== 32'h0) begin
      errors++; $display("FAIL reset_release_wsel: got %h expected 0", wsel);
    end
  endtask

  task automatic test_write_read_all();
    logic [31:0] exp;
    logic [31:0] exp_sel;
    for (int k = 1; k < 32; k++) begin
      exp = 32'(k) * 32'h01010101;
      exp_sel = 32'h1 << k;
      we = 1'b1; waddr = 5'(k); wdata = exp;
      #1;
      checks++;
      if (wsel !== exp_sel || wsel_nb !== exp_sel) begin
        errors++; $display("FAIL wsel_onehot[%0d]: got %h expected %h", k, wsel, exp_sel);
      end
      @(posedge clk); #1;
      model[k] = exp;
    end
    we = 1'b0;
    for (int k = 1; k < 32; k++) begin
      raddr0 = 5'(k); raddr1 = 5'(k);
      #1;
      exp = 32'(k) * 32'h01010101;
      checks++;
      if (rdata0 !== exp || rdata1 !== exp || rdata0_nb !== exp || rdata1_nb !== exp) begin
        errors++;
        $display("FAIL read_all[%0d]: got %h %h %h %h expected %h", k, rdata0, rdata1, rdata0_nb, rdata1_nb, exp);
      end
    end
  endtask

  task automatic test_reg0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr0 = 5'd0; raddr1 = 5'd0;
    #1;
    checks++;
    if (wsel !== 32'h0) begin
      errors++; $display("FAIL reg0_wsel: got %h expected 0", wsel);
    end
    checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0 || rdata0_nb !== 32'h0) begin
      errors++; $display("FAIL reg0_same_cycle: got %h %h expected 0", rdata0, rdata1);
    end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    checks++;
    if (rdata0 !== 32'h0 || rdata0_nb !== 32'h0) begin
      errors++; $display("FAIL reg0_after: got %h/%h expected 0", rdata0, rdata0_nb);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    @(posedge clk); #1;
    model[7] = 32'h11111111;
    wdata = 32'h22222222; raddr0 = 5'd7; raddr1 = 5'd7;
    #1;
    checks++;
    if (rdata0 !== 32'h22222222 || rdata1 !== 32'h22222222) begin
      errors++; $display("FAIL bypass_on: got %h/%h expected 22222222", rdata0, rdata1);
    end
    checks++;
    if (rdata0_nb !== 32'h11111111 || rdata1_nb !== 32'h11111111) begin
      errors++; $display("FAIL bypass_off_before: got %h/%h expected 11111111", rdata0_nb, rdata1_nb);
    end
    raddr1 = 5'd8;
    #1;
    checks++;
    if (rdata1 !== 32'h08080808 || rdata0 !== 32'h22222222) begin
      errors++; $display("FAIL bypass_other_port: got %h/%h expected 22222222/08080808", rdata0, rdata1);
    end
    raddr1 = 5'd7;
    @(posedge clk); #1;
    model[7] = 32'h22222222;
    we = 1'b0;
    #1;
    checks++;
    if (rdata0_nb !== 32'h22222222 || rdata1_nb !== 32'h22222222 || rdata0 !== 32'h22222222) begin
      errors++; $display("FAIL bypass_off_after: got %h/%h expected 22222222", rdata0_nb, rdata1_nb);
    end
  endtask

  task automatic test_async_reset();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    we = 1'b0; raddr0 = 5'd3; raddr1 = 5'd7;
    #1;
    checks++;
    if (rdata0 !== 32'hA5A5A5A5 || rdata0_nb !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL async_pre: got %h/%h expected a5a5a5a5", rdata0, rdata0_nb);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdata0 !== 32'h0 || rdata0_nb !== 32'h0 || rdata1 !== 32'h0) begin
      errors++; $display("FAIL async_clear: got %h/%h/%h expected 0", rdata0, rdata0_nb, rdata1);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    checks++;
    if (rdata0 !== 32'h0 || rdata1_nb !== 32'h0) begin
      errors++; $display("FAIL async_released: got %h/%h expected 0", rdata0, rdata1_nb);
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'h5;
    @(posedge clk); #1;
    model[3] = 32'h5;
    we = 1'b0;
    #1;
    checks++;
    if (rdata0 !== 32'h5 || rdata0_nb !== 32'h5) begin
      errors++; $display("FAIL async_rewrite: got %h/%h expected 00000005", rdata0, rdata0_nb);
    end
  endtask

  task automatic test_we_hold();
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
      #1;
      checks++;
      if (wsel !== 32'h0 || wsel_nb !== 32'h0) begin
        errors++; $display("FAIL hold_wsel[%0d]: got %h expected 0", i, wsel);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 32; k++) begin
      raddr0 = 5'(k); raddr1 = 5'(31 - k);
      #1;
      checks++;
      if (rdata0 !== model[k] || rdata1 !== model[31 - k] || rdata0_nb !== model[k]) begin
        errors++;
        $display("FAIL hold_regs[%0d]: got %h/%h expected %h/%h", k, rdata0, rdata1, model[k], model[31 - k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read_all();
    test_reg0();
    test_bypass();
    test_async_reset();
    test_we_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
